// File: rtl/sram_responder.sv
// sram_responder: turns a valid/ready word request port into synchronous SRAM pin
// timing with a fixed 3-cycle read latency; Rev 1.0
`default_nettype none

module sram_responder #(
  parameter int INIT_CYCLES = 16
) (
  input  logic        sram_clock,
  input  logic        reset,
  input  logic        sram_addr_valid,
  output logic        sram_ready,
  input  logic [17:0] sram_addr,
  input  logic [31:0] sram_data_in,
  input  logic [3:0]  sram_write_mask,
  output logic [31:0] sram_data_out,
  output logic        sram_data_out_valid,
  output logic [17:0] sram_a,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_bw_n,
  output logic [31:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [31:0] sram_dq_in,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] init_cnt;

  logic        accept;
  logic        is_write;

  // s1 = request on the pins, s2 = data phase; the third stage is the read
  // result register itself (sram_data_out_valid)
  logic        s1_valid;
  logic        s1_write;
  logic [31:0] s1_data;
  logic        s2_valid;
  logic        s2_write;

  assign accept   = sram_addr_valid & sram_ready;
  assign is_write = |sram_write_mask;

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == INIT_LAST) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + 16'd1;
    end
  end

  // Registered from the next state so ready rises on the same edge RUN is entered
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) sram_ready <= 1'b0;
    else       sram_ready <= (state_next == RUN);
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      sram_a    <= 18'd0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_bw_n <= 4'hF;
    end else if (accept) begin
      sram_a    <= sram_addr;
      sram_ce_n <= 1'b0;
      sram_we_n <= ~is_write;
      sram_bw_n <= ~sram_write_mask;
    end else begin
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_bw_n <= 4'hF;
    end
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_write <= 1'b0;
      s1_data  <= 32'd0;
      s2_valid <= 1'b0;
      s2_write <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_write <= accept & is_write;
      if (accept) s1_data <= sram_data_in;
      s2_valid <= s1_valid;
      s2_write <= s1_write;
    end
  end

  // Write data occupies the bus only in the data phase, so a following read
  // never collides with it
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= 32'd0;
    end else begin
      sram_dq_oe <= s1_valid & s1_write;
      if (s1_valid & s1_write) sram_dq_out <= s1_data;
    end
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      sram_data_out       <= 32'd0;
      sram_data_out_valid <= 1'b0;
    end else begin
      sram_data_out_valid <= s2_valid & ~s2_write;
      if (s2_valid & ~s2_write) sram_data_out <= sram_dq_in;
    end
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (accept) begin
      if (is_write) wr_count <= wr_count + 16'd1;
      else          rd_count <= rd_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder with a small synchronous SRAM device model.
`default_nettype none

module tb_sram_responder;

  localparam int INIT_CYCLES = 16;

  logic        sram_clock = 1'b0;
  logic        reset = 1'b1;
  logic        sram_addr_valid = 1'b0;
  logic        sram_ready;
  logic [17:0] sram_addr = 18'd0;
  logic [31:0] sram_data_in = 32'd0;
  logic [3:0]  sram_write_mask = 4'h0;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic [17:0] sram_a;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic [3:0]  sram_bw_n;
  logic [31:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_in;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] cyc = 32'd0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [17:0] a;
    logic        we_n;
    logic [3:0]  bw_n;
  } pin_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] d;
  } dat_t;

  pin_t pin_q[$];
  dat_t wr_q[$];
  dat_t rd_q[$];

  sram_responder #(.INIT_CYCLES(INIT_CYCLES)) dut (
    .sram_clock         (sram_clock),
    .reset              (reset),
    .sram_addr_valid    (sram_addr_valid),
    .sram_ready         (sram_ready),
    .sram_addr          (sram_addr),
    .sram_data_in       (sram_data_in),
    .sram_write_mask    (sram_write_mask),
    .sram_data_out      (sram_data_out),
    .sram_data_out_valid(sram_data_out_valid),
    .sram_a             (sram_a),
    .sram_ce_n          (sram_ce_n),
    .sram_we_n          (sram_we_n),
    .sram_bw_n          (sram_bw_n),
    .sram_dq_out        (sram_dq_out),
    .sram_dq_oe         (sram_dq_oe),
    .sram_dq_in         (sram_dq_in),
    .rd_count           (rd_count),
    .wr_count           (wr_count)
  );

  always #5 sram_clock = ~sram_clock;
  always @(posedge sram_clock) cyc <= cyc + 32'd1;

  // Device model: address phase on the pins, data phase one cycle later
  logic [31:0] mem [0:255];
  logic        rd_pend = 1'b0;
  logic        wr_pend = 1'b0;
  logic [7:0]  rd_addr = 8'd0;
  logic [7:0]  wr_addr = 8'd0;
  logic [3:0]  wr_bw = 4'hF;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

  assign sram_dq_in = rd_pend ? mem[rd_addr] : 32'h0;

  always @(posedge sram_clock) begin
    rd_pend <= !reset && !sram_ce_n && sram_we_n;
    wr_pend <= !reset && !sram_ce_n && !sram_we_n;
    rd_addr <= sram_a[7:0];
    wr_addr <= sram_a[7:0];
    wr_bw   <= sram_bw_n;
    if (wr_pend && sram_dq_oe)
      for (int b = 0; b < 4; b++)
        if (!wr_bw[b]) mem[wr_addr][8*b +: 8] <= sram_dq_out[8*b +: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue, cycle included
  always @(negedge sram_clock) begin
    pin_t p;
    dat_t d;
    if (!reset) begin
      if (!sram_ce_n) begin
        if (pin_q.size() == 0) chk("pin_unexpected", {sram_a, sram_we_n, sram_bw_n}, 64'h0);
        else begin
          p = pin_q.pop_front();
          chk("pin_event", {cyc, sram_a, sram_we_n, sram_bw_n}, p);
        end
      end
      if (sram_dq_oe) begin
        if (wr_q.size() == 0) chk("dq_oe_unexpected", {32'd0, sram_dq_out}, 64'h0);
        else begin
          d = wr_q.pop_front();
          chk("dq_drive", {cyc, sram_dq_out}, d);
        end
      end
      if (sram_data_out_valid) begin
        if (rd_q.size() == 0) chk("rd_valid_unexpected", {32'd0, sram_data_out}, 64'h0);
        else begin
          d = rd_q.pop_front();
          chk("rd_data", {cyc, sram_data_out}, d);
        end
      end
    end
  end

  // One request per call; consecutive calls present back-to-back requests
  task automatic issue(input logic [17:0] a, input logic [31:0] dat,
                       input logic [3:0] m, input logic [31:0] exp_data);
    pin_t p;
    dat_t d;
    @(negedge sram_clock);
    sram_addr_valid = 1'b1;
    sram_addr       = a;
    sram_data_in    = dat;
    sram_write_mask = m;
    p.cyc  = cyc + 32'd1;
    p.a    = a;
    p.we_n = (m == 4'h0);
    p.bw_n = ~m;
    pin_q.push_back(p);
    if (m != 4'h0) begin
      d.cyc = cyc + 32'd2;
      d.d   = dat;
      wr_q.push_back(d);
      exp_wr++;
    end else begin
      d.cyc = cyc + 32'd3;
      d.d   = exp_data;
      rd_q.push_back(d);
      exp_rd++;
    end
  endtask

  task automatic idle(input int n);
    @(negedge sram_clock);
    sram_addr_valid = 1'b0;
    sram_write_mask = 4'h0;
    repeat (n) @(negedge sram_clock);
  endtask

  // Holds a write request from reset release; it must not be taken before ready
  task automatic wait_init();
    int got;
    got = -1;
    sram_addr_valid = 1'b1;
    sram_addr       = 18'h3FFFF;
    sram_write_mask = 4'hF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sram_clock);
      if (sram_ready) begin
        got = k;
        break;
      end
    end
    sram_addr_valid = 1'b0;
    sram_write_mask = 4'h0;
    chk("init_ready_cycles", 64'(got), 64'(INIT_CYCLES));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {sram_ready, sram_ce_n, sram_we_n, sram_bw_n, sram_dq_oe, sram_data_out_valid},
        {1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0});
    chk({tag, "_a"}, 64'(sram_a), 64'h0);
    chk({tag, "_dq_out"}, 64'(sram_dq_out), 64'h0);
    chk({tag, "_data_out"}, 64'(sram_data_out), 64'h0);
    chk({tag, "_counts"}, {rd_count, wr_count}, 64'h0);
  endtask

  initial begin
    repeat (3) @(negedge sram_clock);
    chk_reset_vals("reset");
    reset = 1'b0;
    wait_init();

    // Write then read of the same word, alternating with no gap
    issue(18'h00010, 32'hDEADBEEF, 4'hF, 32'h0);
    issue(18'h00010, 32'h0, 4'h0, 32'hDEADBEEF);
    idle(4);

    // Partial write leaves untouched bytes at zero
    issue(18'h00020, 32'hAABBCCDD, 4'b0011, 32'h0);
    idle(3);
    issue(18'h00020, 32'h0, 4'h0, 32'h0000CCDD);
    issue(18'h00021, 32'h11223344, 4'b0101, 32'h0);
    idle(4);
    chk("counts_a", {rd_count, wr_count}, {16'(exp_rd), 16'(exp_wr)});

    // Reset one cycle after a read is accepted
    issue(18'h00010, 32'h0, 4'h0, 32'hDEADBEEF);
    @(posedge sram_clock);
    #2;
    sram_addr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("midflight");
    pin_q.delete();
    wr_q.delete();
    rd_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    repeat (3) @(negedge sram_clock);
    reset = 1'b0;
    wait_init();
    idle(5);

    // Streaming: preload 0..7, then eight back-to-back reads
    for (int i = 0; i < 8; i++) issue(18'(i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0);
    idle(3);
    for (int i = 0; i < 8; i++) issue(18'(i), 32'h0, 4'h0, 32'hC0DE0000 + 32'(i));
    idle(4);
    chk("stream_rd_count", 64'(rd_count), 64'd8);
    chk("stream_wr_count", 64'(wr_count), 64'd8);

    // Write counter wrap
    for (int i = exp_wr; i < 65535; i++) issue(18'h00040, 32'(i), 4'h1, 32'h0);
    idle(2);
    chk("wr_count_max", 64'(wr_count), 64'hFFFF);
    issue(18'h00040, 32'h5A5A5A5A, 4'h1, 32'h0);
    idle(4);
    chk("wr_count_wrap", 64'(wr_count), 64'h0);
    chk("rd_count_hold", 64'(rd_count), 64'd8);

    chk("pin_q_empty", 64'(pin_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
